// File: rtl/ascon_ct_reader.sv
// ascon_ct_reader: reader end of the Ascon ciphertext FIFO.
// Pops 64-bit CT blocks, truncates them to the programmed byte count and
// serializes CT followed by the 128-bit tag as 32-bit big-endian words on a
// valid/ready stream.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start_i, pt_size_i    start pulse and CT length in bytes (sampled together)
//   abort_i               synchronous abort back to IDLE, no done
//   ct_empty_i, ct_i      CT FIFO status and head word (first-word-fall-through)
//   ct_pop_o              combinational pop strobe for the CT FIFO head
//   tag_valid_i, tag_i    tag from the AEAD core; first capture wins
//   out_valid_o/out_ready_i/out_data_o/out_tag_o/out_last_o  host stream
//   busy_o, done_o        transaction in progress / one-cycle completion pulse
module ascon_ct_reader #(
  parameter int unsigned DATA_AW = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [DATA_AW-1:0] pt_size_i,
  input  logic               ct_empty_i,
  input  logic [63:0]        ct_i,
  output logic               ct_pop_o,
  input  logic               tag_valid_i,
  input  logic [127:0]       tag_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [31:0]        out_data_o,
  output logic               out_tag_o,
  output logic               out_last_o,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND,
    WAIT_TAG,
    SEND_TAG
  } state_e;

  state_e             state_q, state_d;
  logic [DATA_AW-1:0] rem_q, rem_d;
  logic [63:0]        hold_q, hold_d;
  logic               half_q, half_d;
  logic [127:0]       tag_q, tag_d;
  logic               tag_seen_q, tag_seen_d;
  logic [1:0]         tidx_q, tidx_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        out_data_q, out_data_d;
  logic               out_tag_q, out_tag_d;
  logic               out_last_q, out_last_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ct_pop_c;
  logic               hs_c;
  logic               tag_cap_c;
  logic [DATA_AW-1:0] rem_sub_c;

  // Keep only the r most significant bytes of a CT word when fewer than 4 remain.
  function automatic logic [31:0] mask_word(input logic [31:0] w,
                                            input logic [DATA_AW-1:0] r);
    logic [31:0] m;
    if (r >= DATA_AW'(4))      m = 32'hFFFF_FFFF;
    else if (r == DATA_AW'(3)) m = 32'hFFFF_FF00;
    else if (r == DATA_AW'(2)) m = 32'hFFFF_0000;
    else if (r == DATA_AW'(1)) m = 32'hFF00_0000;
    else                       m = 32'h0000_0000;
    return w & m;
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      hold_q      <= '0;
      half_q      <= 1'b0;
      tag_q       <= '0;
      tag_seen_q  <= 1'b0;
      tidx_q      <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      hold_q      <= hold_d;
      half_q      <= half_d;
      tag_q       <= tag_d;
      tag_seen_q  <= tag_seen_d;
      tidx_q      <= tidx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic; registered outputs are derived from the next state so
  // they line up with the state they describe and stay stable under stall.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    hold_d      = hold_q;
    half_d      = half_q;
    tag_d       = tag_q;
    tag_seen_d  = tag_seen_q;
    tidx_d      = tidx_q;
    done_d      = 1'b0;
    ct_pop_c    = 1'b0;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    out_tag_d   = 1'b0;
    out_last_d  = 1'b0;
    busy_d      = 1'b0;

    hs_c      = out_valid_q && out_ready_i;
    tag_cap_c = (state_q != IDLE) && tag_valid_i && !tag_seen_q;
    rem_sub_c = (rem_q < DATA_AW'(4)) ? rem_q : DATA_AW'(4);

    if (tag_cap_c) begin
      tag_d      = tag_i;
      tag_seen_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          rem_d      = pt_size_i;
          tag_seen_d = 1'b0;
          state_d    = (pt_size_i == '0) ? WAIT_TAG : FETCH;
        end
      end
      FETCH: begin
        if (!ct_empty_i) begin
          ct_pop_c = 1'b1;
          hold_d   = ct_i;
          half_d   = 1'b0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (hs_c) begin
          rem_d = rem_q - rem_sub_c;
          // Ending here also skips a trailing unused half of the block.
          if (rem_q <= DATA_AW'(4)) state_d = WAIT_TAG;
          else if (half_q)          state_d = FETCH;
          else                      half_d  = 1'b1;
        end
      end
      WAIT_TAG: begin
        if (tag_seen_q || tag_cap_c) begin
          state_d = SEND_TAG;
          tidx_d  = 2'd0;
        end
      end
      SEND_TAG: begin
        if (hs_c) begin
          tidx_d = tidx_q + 2'd1;
          if (tidx_q == 2'd3) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides everything decided above.
    if (abort_i) begin
      state_d    = IDLE;
      rem_d      = rem_q;
      hold_d     = hold_q;
      half_d     = half_q;
      tag_d      = tag_q;
      tidx_d     = tidx_q;
      tag_seen_d = 1'b0;
      ct_pop_c   = 1'b0;
      done_d     = 1'b0;
    end

    out_valid_d = (state_d == SEND) || (state_d == SEND_TAG);
    out_tag_d   = (state_d == SEND_TAG);
    out_last_d  = (state_d == SEND_TAG) && (tidx_d == 2'd3);
    busy_d      = (state_d != IDLE);

    if (state_d == SEND) begin
      out_data_d = mask_word(half_d ? hold_d[31:0] : hold_d[63:32], rem_d);
    end else if (state_d == SEND_TAG) begin
      case (tidx_d)
        2'd0:    out_data_d = tag_d[127:96];
        2'd1:    out_data_d = tag_d[95:64];
        2'd2:    out_data_d = tag_d[63:32];
        default: out_data_d = tag_d[31:0];
      endcase
    end

    if (abort_i) out_data_d = '0;
  end

  assign ct_pop_o    = ct_pop_c;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_tag_o   = out_tag_q;
  assign out_last_o  = out_last_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_ascon_ct_reader.sv
// Testbench for ascon_ct_reader: FIFO model, scoreboard of expected output
// words, and one task per scenario.
module tb_ascon_ct_reader;

  localparam int unsigned DATA_AW = 7;

  logic               clk;
  logic               rst_n;
  logic               start_i;
  logic               abort_i;
  logic [DATA_AW-1:0] pt_size_i;
  logic               ct_empty_i;
  logic [63:0]        ct_i;
  logic               ct_pop_o;
  logic               tag_valid_i;
  logic [127:0]       tag_i;
  logic               out_valid_o;
  logic               out_ready_i;
  logic [31:0]        out_data_o;
  logic               out_tag_o;
  logic               out_last_o;
  logic               busy_o;
  logic               done_o;

  ascon_ct_reader #(.DATA_AW(DATA_AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .pt_size_i   (pt_size_i),
    .ct_empty_i  (ct_empty_i),
    .ct_i        (ct_i),
    .ct_pop_o    (ct_pop_o),
    .tag_valid_i (tag_valid_i),
    .tag_i       (tag_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_tag_o   (out_tag_o),
    .out_last_o  (out_last_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        tag;
    logic        last;
  } exp_t;

  localparam logic [127:0] TAG_A = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] TAG_B = 128'hDEADBEEF_CAFEF00D_11111111_22222222;

  exp_t        exp_q[$];
  logic [63:0] fifo_q[$];
  int          errors;
  int          checks;
  int          pop_cnt;
  int          done_cnt;
  bit          pop_pend;
  bit          stall_empty;
  bit          prev_stall;
  bit          prev_abort;
  logic [31:0] prev_data;
  logic        prev_tag;
  logic        prev_last;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  // FIFO model: pop the head at the edge where the DUT strobed ct_pop_o.
  always @(posedge clk) begin
    if (pop_pend && fifo_q.size() > 0) void'(fifo_q.pop_front());
    pop_pend = 1'b0;
    #2;
    ct_empty_i = (fifo_q.size() == 0) || stall_empty;
    ct_i       = (fifo_q.size() > 0) ? fifo_q[0] : 64'h0;
  end

  // Monitor: scoreboard on handshakes, stall stability, pop legality.
  always @(negedge clk) begin
    if (!rst_n) begin
      pop_pend   = 1'b0;
      prev_stall = 1'b0;
      prev_abort = 1'b0;
    end else begin
      pop_pend = ct_pop_o;
      if (ct_pop_o) pop_cnt++;
      if (done_o) done_cnt++;
      if (ct_empty_i) begin
        checks++;
        if (ct_pop_o !== 1'b0) begin
          errors++;
          $display("FAIL pop_while_empty: ct_pop_o=%b required 0", ct_pop_o);
        end
      end
      if (prev_stall && !prev_abort) begin
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== prev_data ||
            out_tag_o !== prev_tag || out_last_o !== prev_last) begin
          errors++;
          $display("FAIL stall_stable: got v=%b d=%h t=%b l=%b required v=1 d=%h t=%b l=%b",
                   out_valid_o, out_data_o, out_tag_o, out_last_o, prev_data, prev_tag, prev_last);
        end
      end
      if (out_valid_o && out_ready_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got d=%h t=%b l=%b required no word",
                   out_data_o, out_tag_o, out_last_o);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (out_data_o !== e.data || out_tag_o !== e.tag || out_last_o !== e.last) begin
            errors++;
            $display("FAIL sb_word: got d=%h t=%b l=%b required d=%h t=%b l=%b",
                     out_data_o, out_tag_o, out_last_o, e.data, e.tag, e.last);
          end
        end
      end
      prev_stall = out_valid_o && !out_ready_i;
      prev_abort = abort_i;
      prev_data  = out_data_o;
      prev_tag   = out_tag_o;
      prev_last  = out_last_o;
    end
  end

  // Reference model: bytes of the FIFO contents, truncated and zero padded,
  // followed by the four tag words.
  task automatic load_expected(input int size, input logic [127:0] tg);
    int          words;
    logic [63:0] blk;
    exp_t        e;
    words = (size + 3) / 4;
    for (int i = 0; i < words; i++) begin
      e.data = 32'h0;
      e.tag  = 1'b0;
      e.last = 1'b0;
      for (int b = 0; b < 4; b++) begin
        int idx;
        idx = 4 * i + b;
        if (idx < size) begin
          blk = fifo_q[idx / 8];
          e.data[31 - 8 * b -: 8] = blk[63 - 8 * (idx % 8) -: 8];
        end
      end
      exp_q.push_back(e);
    end
    for (int t = 0; t < 4; t++) begin
      e.data = tg[127 - 32 * t -: 32];
      e.tag  = 1'b1;
      e.last = (t == 3);
      exp_q.push_back(e);
    end
  endtask

  task automatic start_txn(input int size);
    pop_cnt  = 0;
    done_cnt = 0;
    @(posedge clk); #1;
    pt_size_i = DATA_AW'(size);
    start_i   = 1'b1;
    @(posedge clk); #1;
    start_i   = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int n;
    n = 0;
    while (done_cnt == 0 && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL done_timeout: done seen %0d times, required 1 within %0d cycles", done_cnt, max_cyc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid_o, out_tag_o, out_last_o, busy_o, done_o, ct_pop_o} !== 6'b0 || out_data_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b t=%b l=%b b=%b d=%b p=%b data=%h required all 0",
               out_valid_o, out_tag_o, out_last_o, busy_o, done_o, ct_pop_o, out_data_o);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got v=%b busy=%b required 0 0", out_valid_o, busy_o);
    end
  endtask

  task automatic test_basic16();
    fifo_q.delete();
    fifo_q.push_back(64'h0011223344556677);
    fifo_q.push_back(64'h8899AABBCCDDEEFF);
    load_expected(16, TAG_A);
    tag_i = TAG_A; tag_valid_i = 1'b1;
    start_txn(16);
    checks++;
    if (busy_o !== 1'b1 || out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL latency_fetch: got busy=%b valid=%b required 1 0", busy_o, out_valid_o);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid_o !== 1'b1 || out_data_o !== 32'h00112233) begin
      errors++;
      $display("FAIL latency_first: got valid=%b data=%h required 1 00112233", out_valid_o, out_data_o);
    end
    wait_done(100);
    tag_valid_i = 1'b0;
    checks++;
    if (exp_q.size() != 0 || pop_cnt != 2) begin
      errors++;
      $display("FAIL basic16_counts: got left=%0d pops=%0d required 0 2", exp_q.size(), pop_cnt);
    end
    @(posedge clk); #1;
    checks++;
    if (done_cnt != 1 || done_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL basic16_done: got dones=%0d done=%b busy=%b required 1 0 0", done_cnt, done_o, busy_o);
    end
  endtask

  task automatic test_size5();
    fifo_q.delete();
    fifo_q.push_back(64'hA1A2A3A4A5A6A7A8);
    load_expected(5, TAG_B);
    tag_i = TAG_B; tag_valid_i = 1'b1;
    start_txn(5);
    wait_done(100);
    tag_valid_i = 1'b0;
    checks++;
    if (exp_q.size() != 0 || pop_cnt != 1) begin
      errors++;
      $display("FAIL size5_counts: got left=%0d pops=%0d required 0 1", exp_q.size(), pop_cnt);
    end
  endtask

  task automatic test_size0();
    fifo_q.delete();
    fifo_q.push_back(64'h1234567812345678);
    load_expected(0, TAG_A);
    tag_i = TAG_A; tag_valid_i = 1'b1;
    start_txn(0);
    wait_done(100);
    tag_valid_i = 1'b0;
    checks++;
    if (exp_q.size() != 0 || pop_cnt != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL size0_counts: got left=%0d pops=%0d dones=%0d required 0 0 1",
               exp_q.size(), pop_cnt, done_cnt);
    end
    fifo_q.delete();
  endtask

  task automatic test_stall();
    int n;
    int stall_left;
    bit stalled;
    fifo_q.delete();
    fifo_q.push_back(64'h0011223344556677);
    fifo_q.push_back(64'h8899AABBCCDDEEFF);
    load_expected(16, TAG_A);
    tag_i = TAG_A; tag_valid_i = 1'b1;
    start_txn(16);
    n = 0; stall_left = 0; stalled = 1'b0;
    while (done_cnt == 0 && n < 300) begin
      out_ready_i = (n % 4 == 0) || (n % 4 == 3);
      if (!stalled && pop_cnt >= 1) begin
        stalled = 1'b1; stall_left = 5; stall_empty = 1'b1;
      end else if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) stall_empty = 1'b0;
      end
      // A start pulse mid-transaction must be ignored.
      start_i   = (n == 6);
      pt_size_i = DATA_AW'(0);
      @(posedge clk); #1;
      n++;
    end
    start_i = 1'b0; stall_empty = 1'b0; out_ready_i = 1'b1; tag_valid_i = 1'b0;
    checks++;
    if (done_cnt != 1 || exp_q.size() != 0 || pop_cnt != 2) begin
      errors++;
      $display("FAIL stall_counts: got dones=%0d left=%0d pops=%0d required 1 0 2",
               done_cnt, exp_q.size(), pop_cnt);
    end
  endtask

  task automatic test_tag_pulse();
    fifo_q.delete();
    fifo_q.push_back(64'h0011223344556677);
    fifo_q.push_back(64'h8899AABBCCDDEEFF);
    load_expected(16, TAG_A);
    tag_valid_i = 1'b0;
    start_txn(16);
    // DUT is in FETCH of block 1 during this cycle.
    tag_i = TAG_A; tag_valid_i = 1'b1;
    @(posedge clk); #1;
    tag_valid_i = 1'b0; tag_i = 128'h0;
    repeat (2) @(posedge clk);
    #1;
    tag_i = TAG_B; tag_valid_i = 1'b1;
    @(posedge clk); #1;
    tag_valid_i = 1'b0; tag_i = 128'h0;
    wait_done(100);
    checks++;
    if (exp_q.size() != 0 || pop_cnt != 2) begin
      errors++;
      $display("FAIL tag_pulse_counts: got left=%0d pops=%0d required 0 2", exp_q.size(), pop_cnt);
    end
  endtask

  task automatic run_to_tag(input bit use_reset);
    int n;
    fifo_q.delete();
    fifo_q.push_back(64'hF0E1D2C3B4A59687);
    load_expected(8, TAG_B);
    tag_i = TAG_B; tag_valid_i = 1'b1;
    start_txn(8);
    n = 0;
    while (out_tag_o !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    out_ready_i = 1'b0;
    checks++;
    if (out_tag_o !== 1'b1) begin
      errors++;
      $display("FAIL reach_send_tag: got out_tag=%b required 1", out_tag_o);
    end
    if (use_reset) begin
      rst_n = 1'b0;
      #1;
    end else begin
      abort_i = 1'b1;
      @(posedge clk); #1;
      abort_i = 1'b0;
    end
    checks++;
    if ({out_valid_o, out_tag_o, out_last_o, busy_o, done_o} !== 5'b0 || out_data_o !== 32'h0) begin
      errors++;
      $display("FAIL %s_clear: got v=%b t=%b l=%b b=%b done=%b data=%h required all 0",
               use_reset ? "reset" : "abort", out_valid_o, out_tag_o, out_last_o, busy_o, done_o, out_data_o);
    end
    exp_q.delete();
    if (use_reset) begin
      @(posedge clk); #1;
      rst_n = 1'b1;
    end
    out_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != 0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_no_done: got dones=%0d busy=%b required 0 0",
               use_reset ? "reset" : "abort", done_cnt, busy_o);
    end
    // Fresh transaction after the interruption.
    fifo_q.delete();
    fifo_q.push_back(64'h0123456789ABCDEF);
    load_expected(8, TAG_A);
    tag_i = TAG_A;
    start_txn(8);
    wait_done(100);
    tag_valid_i = 1'b0;
    checks++;
    if (exp_q.size() != 0 || pop_cnt != 1) begin
      errors++;
      $display("FAIL restart_counts: got left=%0d pops=%0d required 0 1", exp_q.size(), pop_cnt);
    end
  endtask

  task automatic test_abort_vs_start();
    @(posedge clk); #1;
    pt_size_i = DATA_AW'(8);
    start_i = 1'b1; abort_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; abort_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_vs_start: got busy=%b valid=%b required 0 0", busy_o, out_valid_o);
    end
  endtask

  initial begin
    errors = 0; checks = 0; pop_cnt = 0; done_cnt = 0;
    pop_pend = 1'b0; stall_empty = 1'b0; prev_stall = 1'b0; prev_abort = 1'b0;
    prev_data = 32'h0; prev_tag = 1'b0; prev_last = 1'b0;
    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; pt_size_i = '0;
    ct_empty_i = 1'b1; ct_i = 64'h0; tag_valid_i = 1'b0; tag_i = 128'h0;
    out_ready_i = 1'b1;

    test_reset();
    test_basic16();
    test_size5();
    test_size0();
    test_stall();
    test_tag_pulse();
    run_to_tag(1'b0);
    run_to_tag(1'b1);
    test_abort_vs_start();

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
